// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline-stage register.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } stage_state_t;

   localparam int OCC_W = 2;

endpackage

// File: rtl/pipe_slot.sv
// One payload register plus its valid bit; used as the main and skid entries.
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              clear,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q,
   output logic              valid
);

   // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
   // so slots chained through main_d/skid_q shift correctly in one edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         // NOTE: the payload is reset too because out_data must read 0 after
         // reset; a pure storage array would normally be left unreset.
         q     <= '0;
         valid <= 1'b0;
      end else begin
         if (load && !clear) q <= d;
         if (clear)          valid <= 1'b0;
         else if (load)      valid <= 1'b1;
      end
   end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic valid/ready pipeline stage: two-entry skid (SKID=1) or a single
// half-throughput entry (SKID=0), with synchronous flush.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter bit SKID   = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   input  logic              flush,
   output logic [OCC_W-1:0]  occupancy
);

   stage_state_t      state, state_next;
   logic              in_ready_next;
   logic              accept, pop;
   logic              main_load, main_clear, skid_load, skid_clear;
   logic [DATA_W-1:0] main_d, skid_q;
   logic              main_valid, skid_valid;

   assign accept = in_valid & in_ready;
   assign pop    = out_valid & out_ready;

   always_comb begin
      // NOTE: every output of this block is defaulted first so no path
      // through the case leaves one unassigned and infers a latch.
      state_next = state;
      main_load  = 1'b0;
      main_clear = 1'b0;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      case (state)
         EMPTY: begin
            if (accept) begin
               state_next = ONE;
               main_load  = 1'b1;
            end
         end
         ONE: begin
            if (accept && pop) begin
               main_load = 1'b1;
            end else if (accept && SKID) begin
               state_next = TWO;
               skid_load  = 1'b1;
            end else if (pop) begin
               state_next = EMPTY;
               main_clear = 1'b1;
            end
         end
         TWO: begin
            if (pop) begin
               state_next = ONE;
               main_load  = 1'b1;
               skid_clear = 1'b1;
            end
         end
         default: state_next = EMPTY;
      endcase

      // Squash wins over everything; an offered beat is dropped.
      if (flush) begin
         state_next = EMPTY;
         main_load  = 1'b0;
         skid_load  = 1'b0;
         main_clear = 1'b1;
         skid_clear = 1'b1;
      end

      in_ready_next = SKID ? (state_next != TWO) : (state_next == EMPTY);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= EMPTY;
         in_ready <= 1'b0;
      end else begin
         state    <= state_next;
         in_ready <= in_ready_next;
      end
   end

   // Leaving TWO, the older skid beat moves up into main.
   assign main_d = (state == TWO) ? skid_q : in_data;

   pipe_slot #(.DATA_W(DATA_W)) u_main (
      .clk   (clk),
      .reset (reset),
      .load  (main_load),
      .clear (main_clear),
      .d     (main_d),
      .q     (out_data),
      .valid (main_valid)
   );

   if (SKID) begin : g_skid
      pipe_slot #(.DATA_W(DATA_W)) u_skid (
         .clk   (clk),
         .reset (reset),
         .load  (skid_load),
         .clear (skid_clear),
         .d     (in_data),
         .q     (skid_q),
         .valid (skid_valid)
      );
   end else begin : g_no_skid
      assign skid_q     = '0;
      assign skid_valid = 1'b0;
   end

   assign out_valid = main_valid;
   assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: SKID=1 and SKID=0 instances share stimulus,
// each tracked by its own FIFO scoreboard plus directed scenario checks.
module tb_pipe_stage_skid;

   localparam int W = 64;

   logic          clk = 1'b0;
   logic          reset, in_valid, out_ready, flush;
   logic [W-1:0]  in_data;
   logic          rdy1, ov1, rdy0, ov0;
   logic [W-1:0]  od1, od0;
   logic [1:0]    occ1, occ0;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] q1[$];
   logic [W-1:0] q0[$];
   logic         er1, er0, rst_seen;

   always #5 clk = ~clk;

   pipe_stage_skid #(.DATA_W(W), .SKID(1'b1)) u_dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy1), .out_valid(ov1), .out_data(od1), .out_ready(out_ready),
      .flush(flush), .occupancy(occ1)
   );

   pipe_stage_skid #(.DATA_W(W), .SKID(1'b0)) u_dut0 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy0), .out_valid(ov0), .out_data(od0), .out_ready(out_ready),
      .flush(flush), .occupancy(occ0)
   );

   // Drive one cycle of stimulus, advance both models across the edge,
   // then compare each DUT with its model.
   task automatic step(input logic v, input logic [W-1:0] d, input logic r,
                       input logic f, input logic rst);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      flush     = f;
      reset     = rst;
      if (!rst) begin
         q1.delete();
         q0.delete();
         er1 = 1'b0;
         er0 = 1'b0;
      end else begin
         if (q1.size() > 0 && r) void'(q1.pop_front());
         if (f) q1.delete();
         else if (v && er1) q1.push_back(d);
         er1 = (q1.size() < 2);
         if (q0.size() > 0 && r) void'(q0.pop_front());
         if (f) q0.delete();
         else if (v && er0) q0.push_back(d);
         er0 = (q0.size() == 0);
      end
      rst_seen = !rst;
      @(posedge clk);
      @(negedge clk);

      total++;
      if (occ1 !== 2'(q1.size())) begin
         bad++; $display("FAIL sb_occ1: got %0d want %0d", occ1, q1.size());
      end
      total++;
      if (ov1 !== (q1.size() != 0)) begin
         bad++; $display("FAIL sb_valid1: got %b want %b", ov1, q1.size() != 0);
      end
      total++;
      if (rdy1 !== er1) begin
         bad++; $display("FAIL sb_ready1: got %b want %b", rdy1, er1);
      end
      if (q1.size() != 0) begin
         total++;
         if (od1 !== q1[0]) begin
            bad++; $display("FAIL sb_data1: got %h want %h", od1, q1[0]);
         end
      end
      total++;
      if (occ0 !== 2'(q0.size())) begin
         bad++; $display("FAIL sb_occ0: got %0d want %0d", occ0, q0.size());
      end
      total++;
      if (ov0 !== (q0.size() != 0)) begin
         bad++; $display("FAIL sb_valid0: got %b want %b", ov0, q0.size() != 0);
      end
      total++;
      if (rdy0 !== er0) begin
         bad++; $display("FAIL sb_ready0: got %b want %b", rdy0, er0);
      end
      if (q0.size() != 0) begin
         total++;
         if (od0 !== q0[0]) begin
            bad++; $display("FAIL sb_data0: got %h want %h", od0, q0[0]);
         end
      end
      if (rst_seen) begin
         total++;
         if (od1 !== '0 || od0 !== '0) begin
            bad++; $display("FAIL sb_rst_data: got %h/%h want 0", od1, od0);
         end
      end
   endtask

   task automatic test_reset();
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      total++;
      if ({ov1, rdy1, occ1, ov0, rdy0, occ0} !== 8'b0) begin
         bad++; $display("FAIL reset_ctrl: got %b want 0", {ov1, rdy1, occ1, ov0, rdy0, occ0});
      end
      total++;
      if (od1 !== '0) begin
         bad++; $display("FAIL reset_data: got %h want 0", od1);
      end
      step(1'b0, '0, 1'b1, 1'b0, 1'b1);
      total++;
      if (rdy1 !== 1'b1 || rdy0 !== 1'b1) begin
         bad++; $display("FAIL reset_release_ready: got %b%b want 11", rdy1, rdy0);
      end
   endtask

   task automatic test_stream();
      for (int i = 1; i <= 8; i++) begin
         step(1'b1, W'(i), 1'b1, 1'b0, 1'b1);
         total++;
         if (rdy1 !== 1'b1 || ov1 !== 1'b1 || od1 !== W'(i)) begin
            bad++; $display("FAIL stream_%0d: got rdy=%b v=%b d=%h want 1 1 %h", i, rdy1, ov1, od1, W'(i));
         end
      end
      step(1'b0, '0, 1'b1, 1'b0, 1'b1);
      step(1'b0, '0, 1'b1, 1'b0, 1'b1);
      total++;
      if (ov1 !== 1'b0) begin
         bad++; $display("FAIL stream_drain: got %b want 0", ov1);
      end
   endtask

   task automatic test_backpressure();
      step(1'b1, W'('hA), 1'b1, 1'b0, 1'b1);
      step(1'b1, W'('hB), 1'b0, 1'b0, 1'b1);
      total++;
      if (occ1 !== 2'd2 || rdy1 !== 1'b0 || od1 !== W'('hA)) begin
         bad++; $display("FAIL bp_two: got occ=%0d rdy=%b d=%h want 2 0 a", occ1, rdy1, od1);
      end
      step(1'b1, W'('hC), 1'b0, 1'b0, 1'b1);
      total++;
      if (occ1 !== 2'd2 || od1 !== W'('hA) || u_dut1.g_skid.u_skid.q !== W'('hB)) begin
         bad++; $display("FAIL bp_hold: got occ=%0d d=%h skid=%h want 2 a b", occ1, od1, u_dut1.g_skid.u_skid.q);
      end
      step(1'b1, W'('hC), 1'b1, 1'b0, 1'b1);
      total++;
      if (ov1 !== 1'b1 || od1 !== W'('hB) || rdy1 !== 1'b1) begin
         bad++; $display("FAIL bp_b: got v=%b d=%h rdy=%b want 1 b 1", ov1, od1, rdy1);
      end
      step(1'b1, W'('hC), 1'b1, 1'b0, 1'b1);
      total++;
      if (ov1 !== 1'b1 || od1 !== W'('hC)) begin
         bad++; $display("FAIL bp_c: got v=%b d=%h want 1 c", ov1, od1);
      end
      step(1'b0, '0, 1'b1, 1'b0, 1'b1);
      total++;
      if (ov1 !== 1'b0) begin
         bad++; $display("FAIL bp_empty: got %b want 0", ov1);
      end
   endtask

   task automatic test_flush();
      step(1'b1, W'('hA), 1'b1, 1'b0, 1'b1);
      step(1'b1, W'('hB), 1'b0, 1'b0, 1'b1);
      step(1'b1, W'('hC), 1'b0, 1'b1, 1'b1);
      total++;
      if (ov1 !== 1'b0 || occ1 !== 2'd0 || rdy1 !== 1'b1) begin
         bad++; $display("FAIL flush_two: got v=%b occ=%0d rdy=%b want 0 0 1", ov1, occ1, rdy1);
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, '0, 1'b1, 1'b0, 1'b1);
         total++;
         if (ov1 !== 1'b0) begin
            bad++; $display("FAIL flush_leak_%0d: got v=%b d=%h want 0", i, ov1, od1);
         end
      end
   endtask

   task automatic test_skid0_stream();
      int  idx = 1;
      logic acc;
      for (int n = 1; n <= 8; n++) begin
         acc = rdy0 && (idx <= 4);
         step(idx <= 4, W'(idx), 1'b1, 1'b0, 1'b1);
         if (acc) idx++;
         total++;
         if (ov0 !== 1'(n % 2)) begin
            bad++; $display("FAIL skid0_valid_%0d: got %b want %b", n, ov0, 1'(n % 2));
         end
         if (n % 2 == 1) begin
            total++;
            if (od0 !== W'((n + 1) / 2)) begin
               bad++; $display("FAIL skid0_data_%0d: got %h want %h", n, od0, W'((n + 1) / 2));
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      for (int k = 0; k < 2; k++) begin
         step(1'b1, W'('h11), 1'b1, 1'b0, 1'b1);
         step(1'b1, W'('h22), 1'b0, 1'b0, 1'b1);
         total++;
         if (occ1 !== 2'd2) begin
            bad++; $display("FAIL mrst_fill_%0d: got %0d want 2", k, occ1);
         end
         step(1'b1, W'('h33), 1'b1, k == 1, 1'b0);
         total++;
         if (ov1 !== 1'b0 || od1 !== '0 || rdy1 !== 1'b0 || occ1 !== 2'd0) begin
            bad++; $display("FAIL mrst_clear_%0d: got v=%b d=%h rdy=%b occ=%0d want 0 0 0 0", k, ov1, od1, rdy1, occ1);
         end
         step(1'b0, '0, 1'b1, 1'b0, 1'b1);
         total++;
         if (rdy1 !== 1'b1 || ov1 !== 1'b0) begin
            bad++; $display("FAIL mrst_release_%0d: got rdy=%b v=%b want 1 0", k, rdy1, ov1);
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 10000; n++) begin
         step(1'($urandom_range(0, 1)), {$urandom, $urandom},
              1'($urandom_range(0, 1)), $urandom_range(0, 31) == 0,
              !($urandom_range(0, 999) == 0));
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_skid0_stream();
      test_mid_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised elastic pipeline-stage register, the successor to the fixed MEM/WB-style latch banks in the pipelined CPU. Carries one packed payload per beat (control bits, Rd, ALU/memory data concatenated by the instantiating stage) under a valid/ready handshake, with synchronous flush for branch squash. Configurable as a full-throughput two-entry skid buffer or a half-throughput single-entry stage. Every path from the outputs back to the inputs is registered.

## Interface
- DATA_W, 64: payload width in bits; legal values are 1 and above.
- SKID, 1: 1 = two-entry skid, full throughput; 0 = single entry, maximum one beat every 2 cycles.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset. Sampled on rising clk only.
- in_valid  in  1  upstream beat present.
- in_data  in  DATA_W  upstream payload.
- in_ready  out  1  stage can accept; registered.
- out_valid  out  1  head entry valid; registered.
- out_data  out  DATA_W  head entry payload; registered.
- out_ready  in  1  downstream consumes head.
- flush  in  1  squash all held beats.
- occupancy  out  2  number of held entries (0..2).

## Operation
- Accept: in_valid & in_ready. Pop: out_valid & out_ready.
- States (SKID=1): EMPTY, ONE, TWO.
  - EMPTY, accept: go to ONE, main <= in_data.
  - ONE, accept & pop: stay in ONE, main <= in_data.
  - ONE, accept & !pop: go to TWO, skid <= in_data, main unchanged.
  - ONE, !accept & pop: go to EMPTY.
  - TWO, pop: go to ONE, main <= skid. in_ready is 0 in TWO, so no accept can occur.
- SKID=0: only EMPTY and ONE exist. in_ready = (state==EMPTY). An accept in ONE is impossible.
- in_ready next-state: SKID=1 gives 1 unless next state is TWO. SKID=0 gives 1 only if next state is EMPTY.
- Flush has top priority:
  - The next state is EMPTY and both valids clear.
  - A beat offered in the flush cycle is dropped; the upstream sees in_ready as registered, and that beat is lost.
  - A pop in the flush cycle still counts as consumed by downstream.
- Payload registers load only on their own load enables. Contents do not matter while the matching valid is low.
- occupancy = 0, 1 or 2 for EMPTY, ONE or TWO.
- Order is strict FIFO. The main entry is always the older beat.

## Timing
- Reset (reset==0 at a rising edge): out_valid=0, out_data=0, skid=0, occupancy=0, in_ready=0, state=EMPTY.
- The first cycle after reset is released has in_ready=1.
- Latency: a beat accepted at edge N is on out_valid/out_data after edge N, i.e. visible in cycle N+1.
- Throughput:
  - SKID=1 sustains 1 beat/cycle with out_ready held high.
  - SKID=0 sustains 1 beat per 2 cycles.
- Backpressure (SKID=1): out_ready drops with the stage in ONE while in_valid is held.
  - One more beat is absorbed into skid.
  - in_ready falls at the next edge.
  - No beat is lost or duplicated.
- Reset asserted mid-operation: all held beats are discarded on that edge, identical to the reset values above.
- Reset and flush together: reset wins. The result is the same state either way.

## Structure
- Shared package pipe_pkg:
  - typedef enum logic [1:0] {EMPTY, ONE, TWO} stage_state_t.
  - The occupancy width constant.
- Sub-module pipe_slot:
  - One DATA_W register plus a valid bit.
  - Ports: load, clear, d, q, valid.
  - Synchronous active-low reset.
  - Instantiated as main and skid; skid is not generated when SKID=0.
- The top level holds the state register, the registered in_ready and the next-state logic.

## Test plan
- Reset then stream (SKID=1, DATA_W=64, out_ready=1): send 0x1..0x8 on consecutive cycles -> out_data 0x1..0x8 on 8 consecutive cycles, one cycle behind, in_ready constantly 1.
- Backpressure: send 0xA,0xB,0xC with out_ready=0 from the cycle 0xA appears -> 0xA at head, 0xB in skid, occupancy=2, in_ready=0, 0xC held upstream. Raise out_ready -> 0xA,0xB,0xC emerge in order, no gaps after the first.
- Flush in TWO: with 0xA/0xB held and 0xC offered, assert flush -> next cycle out_valid=0, occupancy=0, in_ready=1, 0xC never appears at the output.
- SKID=0 stream: offer 0x1..0x4 continuously, out_ready=1 -> accepts on alternate cycles, out_valid toggles 1,0,1,0, order preserved.
- Mid-stream reset: reset=0 for one cycle while occupancy=2 -> next cycle out_valid=0, out_data=0, in_ready=0; the cycle after, in_ready=1.
- Random valid/ready/flush for 10k cycles against a queue model -> no loss, duplication or reordering outside flush windows, and occupancy matches the model.
